// File: rtl/decode_stage.sv
// decode_stage: DEPTH-entry instruction queue feeding an RV32I/RV64I decoder with a registered output.
// Define DECODE_STAGE_M_EXT_EN to decode the M-extension (mul/div) encodings.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1_addr,
    output logic [4:0]      out_rs2_addr,
    output logic [4:0]      out_rd_addr,
    output logic            out_rd_wren,
    output logic            out_is_pc,
    output logic            out_bru_en,
    output logic            out_bru_unsign,
    output logic            out_mem_wren,
    output logic            out_mem_load,
    output logic            out_mem_unsign,
    output logic [1:0]      out_op_b_sel,
    output logic [3:0]      out_alu_ctrl,
    output logic [2:0]      out_bru_op,
    output logic [2:0]      out_mem_size,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal,
    output logic            out_mdu_en,
    output logic [2:0]      out_mdu_op
);

    localparam int AW = $clog2(DEPTH);
    localparam bit RV64 = (XLEN == 64);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [31:0]     q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            full, head_valid, push, pop;

    assign full       = (count == (AW+1)'(DEPTH));
    assign head_valid = (count != '0);
    assign in_ready   = !full;
    assign push       = in_valid && !full && !flush;
    assign pop        = head_valid && (!out_valid || out_ready) && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= in_instr;
            q_pc[wr_ptr]    <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    logic [31:0] inst;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic        sh_ok_l, sh_ok_r;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign inst = q_instr[rd_ptr];
    assign opc  = inst[6:0];
    assign f3   = inst[14:12];
    assign f7   = inst[31:25];

    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'h000}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    // RV64 shift amounts take six bits, leaving only instr[31:26] as funct.
    assign sh_ok_l = RV64 ? (inst[31:26] == 6'd0) : (f7 == 7'd0);
    assign sh_ok_r = RV64 ? (inst[31:26] == 6'd0 || inst[31:26] == 6'b010000)
                          : (f7 == 7'd0 || f7 == 7'b0100000);

    function automatic logic [3:0] alu_of(input logic [2:0] f, input logic alt);
        unique case (f)
            3'b000: alu_of = alt ? 4'd1 : 4'd0;
            3'b001: alu_of = 4'd2;
            3'b010: alu_of = 4'd3;
            3'b011: alu_of = 4'd7;
            3'b100: alu_of = 4'd5;
            3'b101: alu_of = alt ? 4'd4 : 4'd6;
            3'b110: alu_of = 4'd8;
            3'b111: alu_of = 4'd9;
        endcase
    endfunction

    logic [4:0]      d_rs1, d_rs2;
    logic            d_rd_wren, d_is_pc, d_bru_en, d_bru_unsign;
    logic            d_mem_wren, d_mem_load, d_mem_unsign, d_illegal;
    logic [1:0]      d_op_b_sel;
    logic [3:0]      d_alu;
    logic [2:0]      d_bru_op, d_mem_size;
    logic [XLEN-1:0] d_imm;
`ifdef DECODE_STAGE_M_EXT_EN
    logic            d_mdu_en;
    logic [2:0]      d_mdu_op;
`endif

    always_comb begin
        d_rs1        = 5'd0;
        d_rs2        = 5'd0;
        d_rd_wren    = 1'b0;
        d_is_pc      = 1'b0;
        d_bru_en     = 1'b0;
        d_bru_unsign = 1'b0;
        d_mem_wren   = 1'b0;
        d_mem_load   = 1'b0;
        d_mem_unsign = 1'b0;
        d_illegal    = 1'b0;
        d_op_b_sel   = 2'b00;
        d_alu        = 4'd0;
        d_bru_op     = 3'd0;
        d_mem_size   = 3'd0;
        d_imm        = '0;
`ifdef DECODE_STAGE_M_EXT_EN
        d_mdu_en     = 1'b0;
        d_mdu_op     = 3'd0;
`endif
        unique case (1'b1)
            (opc == OPC_OP): begin
                d_rs1     = inst[19:15];
                d_rs2     = inst[24:20];
                d_rd_wren = 1'b1;
                if (f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
                    d_alu = alu_of(f3, f7[5]);
`ifdef DECODE_STAGE_M_EXT_EN
                else if (f7 == 7'b0000001) begin
                    d_mdu_en = 1'b1;
                    d_mdu_op = f3;
                end
`endif
                else
                    d_illegal = 1'b1;
            end
            (opc == OPC_IMM): begin
                d_rs1      = inst[19:15];
                d_rd_wren  = 1'b1;
                d_op_b_sel = 2'b01;
                d_imm      = imm_i;
                d_alu      = alu_of(f3, f3 == 3'b101 && inst[30]);
                if ((f3 == 3'b001 && !sh_ok_l) || (f3 == 3'b101 && !sh_ok_r))
                    d_illegal = 1'b1;
            end
            (opc == OPC_LUI): begin
                d_rd_wren  = 1'b1;
                d_op_b_sel = 2'b01;
                d_imm      = imm_u;
            end
            (opc == OPC_AUIPC): begin
                d_rd_wren  = 1'b1;
                d_is_pc    = 1'b1;
                d_op_b_sel = 2'b01;
                d_imm      = imm_u;
            end
            (opc == OPC_JAL), (opc == OPC_JALR): begin
                // ALU forms the link address pc+4; the branch unit handles the target.
                d_rd_wren  = 1'b1;
                d_is_pc    = 1'b1;
                d_op_b_sel = 2'b10;
                d_bru_en   = 1'b1;
                d_bru_op   = opc[3] ? 3'd4 : 3'd5;
                d_imm      = opc[3] ? imm_j : imm_i;
                d_rs1      = opc[3] ? 5'd0 : inst[19:15];
                if (!opc[3] && f3 != 3'b000) d_illegal = 1'b1;
            end
            (opc == OPC_BRANCH): begin
                d_rs1        = inst[19:15];
                d_rs2        = inst[24:20];
                d_bru_en     = 1'b1;
                d_bru_unsign = f3[1];
                d_imm        = imm_b;
                unique case (f3)
                    3'b000:         d_bru_op = 3'd6;
                    3'b001:         d_bru_op = 3'd1;
                    3'b100, 3'b110: d_bru_op = 3'd2;
                    3'b101, 3'b111: d_bru_op = 3'd3;
                    default:        d_illegal = 1'b1;
                endcase
            end
            (opc == OPC_LOAD): begin
                d_rs1        = inst[19:15];
                d_rd_wren    = 1'b1;
                d_mem_load   = 1'b1;
                d_op_b_sel   = 2'b01;
                d_imm        = imm_i;
                d_mem_size   = {1'b0, f3[1:0]};
                d_mem_unsign = f3[2];
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) d_illegal = 1'b1;
            end
            (opc == OPC_STORE): begin
                d_rs1      = inst[19:15];
                d_rs2      = inst[24:20];
                d_mem_wren = 1'b1;
                d_op_b_sel = 2'b01;
                d_imm      = imm_s;
                d_mem_size = f3;
                if (f3[2] || f3 == 3'b011) d_illegal = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase
        if (d_illegal) begin
            d_rd_wren  = 1'b0;
            d_mem_wren = 1'b0;
            d_mem_load = 1'b0;
            d_bru_en   = 1'b0;
`ifdef DECODE_STAGE_M_EXT_EN
            d_mdu_en   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_rs1_addr   <= 5'd0;
            out_rs2_addr   <= 5'd0;
            out_rd_addr    <= 5'd0;
            out_rd_wren    <= 1'b0;
            out_is_pc      <= 1'b0;
            out_bru_en     <= 1'b0;
            out_bru_unsign <= 1'b0;
            out_mem_wren   <= 1'b0;
            out_mem_load   <= 1'b0;
            out_mem_unsign <= 1'b0;
            out_op_b_sel   <= 2'b00;
            out_alu_ctrl   <= 4'd0;
            out_bru_op     <= 3'd0;
            out_mem_size   <= 3'd0;
            out_imm        <= '0;
            out_illegal    <= 1'b0;
`ifdef DECODE_STAGE_M_EXT_EN
            out_mdu_en     <= 1'b0;
            out_mdu_op     <= 3'd0;
`endif
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (pop) begin
            out_valid      <= 1'b1;
            out_pc         <= q_pc[rd_ptr];
            out_rs1_addr   <= d_rs1;
            out_rs2_addr   <= d_rs2;
            out_rd_addr    <= inst[11:7];
            out_rd_wren    <= d_rd_wren;
            out_is_pc      <= d_is_pc;
            out_bru_en     <= d_bru_en;
            out_bru_unsign <= d_bru_unsign;
            out_mem_wren   <= d_mem_wren;
            out_mem_load   <= d_mem_load;
            out_mem_unsign <= d_mem_unsign;
            out_op_b_sel   <= d_op_b_sel;
            out_alu_ctrl   <= d_alu;
            out_bru_op     <= d_bru_op;
            out_mem_size   <= d_mem_size;
            out_imm        <= d_imm;
            out_illegal    <= d_illegal;
`ifdef DECODE_STAGE_M_EXT_EN
            out_mdu_en     <= d_mdu_en;
            out_mdu_op     <= d_mdu_op;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifndef DECODE_STAGE_M_EXT_EN
    assign out_mdu_en = 1'b0;
    assign out_mdu_op = 3'd0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks plus randomized traffic scored against a queue-based decode model.
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc, out_pc, out_imm;
    logic [4:0]      out_rs1_addr, out_rs2_addr, out_rd_addr;
    logic            out_rd_wren, out_is_pc, out_bru_en, out_bru_unsign;
    logic            out_mem_wren, out_mem_load, out_mem_unsign, out_illegal, out_mdu_en;
    logic [1:0]      out_op_b_sel;
    logic [3:0]      out_alu_ctrl;
    logic [2:0]      out_bru_op, out_mem_size, out_mdu_op;

    decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
        .out_rd_wren(out_rd_wren), .out_is_pc(out_is_pc), .out_bru_en(out_bru_en),
        .out_bru_unsign(out_bru_unsign), .out_mem_wren(out_mem_wren),
        .out_mem_load(out_mem_load), .out_mem_unsign(out_mem_unsign),
        .out_op_b_sel(out_op_b_sel), .out_alu_ctrl(out_alu_ctrl), .out_bru_op(out_bru_op),
        .out_mem_size(out_mem_size), .out_imm(out_imm), .out_illegal(out_illegal),
        .out_mdu_en(out_mdu_en), .out_mdu_op(out_mdu_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1, rs2, rd;
        logic            rd_wren, is_pc, bru_en, bru_unsign, mem_wren, mem_load, mem_unsign;
        logic [1:0]      op_b;
        logic [3:0]      alu;
        logic [2:0]      bru_op, mem_size;
        logic [XLEN-1:0] imm;
        logic            illegal, mdu_en;
        logic [2:0]      mdu_op;
    } dec_t;

    localparam int ALU_TAB [8] = '{0, 2, 3, 7, 5, 6, 8, 9};
    localparam logic [6:0] OPS [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F,
                                        7'h67, 7'h63, 7'h03, 7'h23, 7'h73};

    int   n_tests = 0, n_fail = 0;
    dec_t qe [$], qm [$];
    dec_t prev_snap;
    bit   stall_prev = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic dec_t sample();
        dec_t s;
        s.pc = out_pc; s.rs1 = out_rs1_addr; s.rs2 = out_rs2_addr; s.rd = out_rd_addr;
        s.rd_wren = out_rd_wren; s.is_pc = out_is_pc; s.bru_en = out_bru_en;
        s.bru_unsign = out_bru_unsign; s.mem_wren = out_mem_wren; s.mem_load = out_mem_load;
        s.mem_unsign = out_mem_unsign; s.op_b = out_op_b_sel; s.alu = out_alu_ctrl;
        s.bru_op = out_bru_op; s.mem_size = out_mem_size; s.imm = out_imm;
        s.illegal = out_illegal; s.mdu_en = out_mdu_en; s.mdu_op = out_mdu_op;
        return s;
    endfunction

    // Expected decode plus a mask of the fields the instruction class defines.
    function automatic void model(input logic [31:0] i, input logic [XLEN-1:0] pc,
                                  output dec_t e, output dec_t m);
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit ok;
        longint v;
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25]; ok = 1; v = 0;
        e = '0; m = '0;
        e.pc = pc;
        m.pc = '1; m.rd_wren = 1; m.is_pc = 1; m.bru_en = 1; m.bru_unsign = 1;
        m.mem_wren = 1; m.mem_load = 1; m.mem_unsign = 1; m.op_b = '1; m.bru_op = '1;
        m.illegal = 1; m.mdu_en = 1; m.mdu_op = '1;
        case (op)
            7'h33: begin
                m.rs1 = '1; m.rs2 = '1; m.rd = '1; m.alu = '1;
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.rd_wren = 1;
                if (f7 == 7'h00) e.alu = 4'(ALU_TAB[f3]);
                else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 4'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'd4;
`ifdef DECODE_STAGE_M_EXT_EN
                else if (f7 == 7'h01) begin e.mdu_en = 1; e.mdu_op = f3; end
`endif
                else ok = 0;
            end
            7'h13: begin
                m.rs1 = '1; m.rd = '1; m.alu = '1; m.imm = '1;
                e.rs1 = i[19:15]; e.rd = i[11:7]; e.rd_wren = 1; e.op_b = 2'd1;
                v = longint'(i[31:20]); if (i[31]) v -= 4096;
                if (f3 == 3'd1) begin ok = (f7 == 7'h00); e.alu = 4'd2; end
                else if (f3 == 3'd5) begin
                    ok = (f7 == 7'h00 || f7 == 7'h20);
                    e.alu = i[30] ? 4'd4 : 4'd6;
                end
                else e.alu = 4'(ALU_TAB[f3]);
            end
            7'h37, 7'h17: begin
                m.rd = '1; m.alu = '1; m.imm = '1;
                if (op == 7'h37) m.rs1 = '1; else e.is_pc = 1;
                e.rd = i[11:7]; e.rd_wren = 1; e.op_b = 2'd1;
                v = longint'(i[31:12]) * 4096; if (i[31]) v -= 64'sh1_0000_0000;
            end
            7'h6F, 7'h67: begin
                m.rd = '1; m.alu = '1; m.imm = '1;
                e.rd = i[11:7]; e.rd_wren = 1; e.is_pc = 1; e.op_b = 2'd2; e.bru_en = 1;
                if (op == 7'h6F) begin
                    e.bru_op = 3'd4;
                    v = longint'({i[31], i[19:12], i[20], i[30:21]}) * 2;
                    if (i[31]) v -= 64'sh20_0000;
                end else begin
                    m.rs1 = '1; e.rs1 = i[19:15]; e.bru_op = 3'd5; ok = (f3 == 3'd0);
                    v = longint'(i[31:20]); if (i[31]) v -= 4096;
                end
            end
            7'h63: begin
                m.rs1 = '1; m.rs2 = '1; m.imm = '1;
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.bru_en = 1;
                v = longint'({i[31], i[7], i[30:25], i[11:8]}) * 2; if (i[31]) v -= 8192;
                case (f3)
                    3'd0: e.bru_op = 3'd6;
                    3'd1: e.bru_op = 3'd1;
                    3'd4: e.bru_op = 3'd2;
                    3'd5: e.bru_op = 3'd3;
                    3'd6: begin e.bru_op = 3'd2; e.bru_unsign = 1; end
                    3'd7: begin e.bru_op = 3'd3; e.bru_unsign = 1; end
                    default: ok = 0;
                endcase
            end
            7'h03: begin
                m.rs1 = '1; m.rd = '1; m.alu = '1; m.imm = '1; m.mem_size = '1;
                e.rs1 = i[19:15]; e.rd = i[11:7]; e.rd_wren = 1; e.mem_load = 1; e.op_b = 2'd1;
                e.mem_size = {1'b0, f3[1:0]}; e.mem_unsign = f3[2];
                ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                v = longint'(i[31:20]); if (i[31]) v -= 4096;
            end
            7'h23: begin
                m.rs1 = '1; m.rs2 = '1; m.alu = '1; m.imm = '1; m.mem_size = '1;
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.mem_wren = 1; e.op_b = 2'd1;
                e.mem_size = f3; ok = (f3 < 3'd3);
                v = longint'({i[31:25], i[11:7]}); if (i[31]) v -= 4096;
            end
            default: ok = 0;
        endcase
        e.imm = XLEN'(v);
        if (!ok) begin
            e = '0; e.pc = pc; e.illegal = 1;
            m = '0; m.pc = '1; m.illegal = 1; m.rd_wren = 1; m.mem_wren = 1;
            m.mem_load = 1; m.bru_en = 1; m.mdu_en = 1;
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k, r;
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 10) w[6:0] = OPS[k];
        r = $urandom_range(0, 3);
        if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
            if (r == 0) w[31:25] = 7'h00;
            else if (r == 1) w[31:25] = 7'h20;
            else if (r == 2) w[31:25] = 7'h01;
        end
        return w;
    endfunction

    // Called after inputs are set, before the edge that acts on them.
    task automatic model_step();
        dec_t e, m, s;
        s = sample();
        if (stall_prev) check("hold", 128'(s), 128'(prev_snap));
        check("in_ready", 128'(in_ready), 128'((qe.size() - int'(out_valid)) < DEPTH));
        stall_prev = out_valid && !out_ready && !rst && !flush;
        prev_snap = s;
        if (rst) begin
            qe.delete(); qm.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (qe.size() == 0) check("spurious", 128'(out_valid), 128'(0));
                else begin
                    e = qe.pop_front(); m = qm.pop_front();
                    check("dec", 128'(s & m), 128'(e & m));
                end
            end
            if (flush) begin
                qe.delete(); qm.delete();
            end else if (in_valid && in_ready) begin
                model(in_instr, in_pc, e, m);
                qe.push_back(e); qm.push_back(m);
            end
        end
    endtask

    task automatic present(input logic [31:0] ins, input logic [XLEN-1:0] pc);
        in_instr = ins; in_pc = pc; in_valid = 1; out_ready = 0;
        tick();
        in_valid = 0;
        tick();
    endtask

    task automatic consume();
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    initial begin
        int acc, got, outs, seen;
        dec_t snap;
        rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = '0; in_pc = '0;
        tick(); tick();
        check("rst_out", 128'(sample()), 128'(0));
        check("rst_valid", 128'(out_valid), 128'(0));
        rst = 0;
        check("rst_ready", 128'(in_ready), 128'(1));
        tick();

        // addi x1,x0,5: one edge to enqueue, one to present
        in_instr = 32'h00500093; in_pc = '0; in_valid = 1;
        tick();
        in_valid = 0;
        check("addi_lat1", 128'(out_valid), 128'(0));
        tick();
        check("addi_valid", 128'(out_valid), 128'(1));
        check("addi_rd", 128'(out_rd_addr), 128'(1));
        check("addi_opb", 128'(out_op_b_sel), 128'(1));
        check("addi_alu", 128'(out_alu_ctrl), 128'(0));
        check("addi_imm", 128'(out_imm), 128'(5));
        consume();
        check("addi_done", 128'(out_valid), 128'(0));

        present(32'hFFFFF0B7, XLEN'(4));
        check("lui_imm", 128'(out_imm), 128'(XLEN'(64'hFFFF_FFFF_FFFF_F000)));
        check("lui_opb", 128'(out_op_b_sel), 128'(1));
        check("lui_rs1", 128'(out_rs1_addr), 128'(0));
        check("lui_pc", 128'(out_pc), 128'(4));
        consume();
        present(32'h4010D093, XLEN'(8));
        check("srai_alu", 128'(out_alu_ctrl), 128'(4));
        check("srai_ill", 128'(out_illegal), 128'(0));
        consume();
        present(32'h022081B3, XLEN'(12));
`ifdef DECODE_STAGE_M_EXT_EN
        check("mul_mdu", 128'({out_mdu_en, out_mdu_op}), 128'(4'b1000));
        check("mul_ill", 128'({out_illegal, out_rd_wren}), 128'(2'b01));
`else
        check("mul_mdu", 128'({out_mdu_en, out_mdu_op}), 128'(0));
        check("mul_ill", 128'({out_illegal, out_rd_wren}), 128'(2'b10));
`endif
        consume();

        // Back-pressure: DEPTH queued plus one in the output register
        acc = 0; got = 0; out_ready = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1; in_pc = XLEN'(32'h100 + 4 * acc);
            in_instr = {12'(acc), 5'd0, 3'd0, 5'd1, 7'h13};
            if (in_ready) acc++;
            tick();
        end
        check("fill_cnt", 128'(acc), 128'(DEPTH + 1));
        check("fill_ready", 128'(in_ready), 128'(0));
        snap = sample();
        tick(); tick();
        check("stall_stable", 128'(sample()), 128'(snap));
        out_ready = 1;
        for (int c = 0; c < 50 && got < 8; c++) begin
            in_valid = (acc < 8); in_pc = XLEN'(32'h100 + 4 * acc);
            in_instr = {12'(acc), 5'd0, 3'd0, 5'd1, 7'h13};
            if (out_valid) begin
                check("order_pc", 128'(out_pc), 128'(32'h100 + 4 * got));
                check("order_imm", 128'(out_imm), 128'(got));
                got++;
            end
            if (in_valid && in_ready) acc++;
            tick();
        end
        check("drain_cnt", 128'(got), 128'(8));
        in_valid = 0;

        // Flush with a queue full and output valid
        out_ready = 0;
        for (int c = 0; c < 10 && in_ready; c++) begin
            in_valid = 1; in_pc = XLEN'(32'h200 + 4 * c);
            tick();
        end
        check("flush_pre", 128'({in_ready, out_valid}), 128'(2'b01));
        flush = 1; in_valid = 1;
        tick();
        flush = 0; in_valid = 0;
        check("flush_valid", 128'(out_valid), 128'(0));
        check("flush_ready", 128'(in_ready), 128'(1));
        out_ready = 1; seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) seen++;
            tick();
        end
        check("flush_quiet", 128'(seen), 128'(0));

        // Sustained one-per-cycle flow
        outs = 0; in_instr = 32'h00000013;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1; out_ready = 1;
            if (out_valid) outs++;
            tick();
        end
        check("thru", 128'(outs), 128'(18));
        in_valid = 0;
        tick(); tick(); tick();
        check("thru_empty", 128'(out_valid), 128'(0));

        // Reset mid-transfer wins over flush and handshakes
        out_ready = 0; in_valid = 1;
        tick(); tick();
        rst = 1; flush = 1;
        tick();
        rst = 0; flush = 0; in_valid = 0;
        check("rstmid_valid", 128'(out_valid), 128'(0));
        check("rstmid_ready", 128'(in_ready), 128'(1));
        out_ready = 1; seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) seen++;
            tick();
        end
        check("rstmid_quiet", 128'(seen), 128'(0));

        // Randomized traffic against the queue model
        stall_prev = 0;
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = XLEN'($urandom) & ~XLEN'(3);
            model_step();
            tick();
        end
        rst = 0; flush = 0; in_valid = 0; out_ready = 1;
        for (int c = 0; c < 20 && qe.size() != 0; c++) begin
            model_step();
            tick();
        end
        check("drained", 128'(qe.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
